// File: rtl/bg_noise_if.sv
// Bus between the background-noise estimator and its producer/consumer.
// The vector source drives start/abort/PeriodData; the estimator returns the
// averaged noise vector plus status.
interface bg_noise_if #(
    parameter int LANES   = 16,
    parameter int DATA_W  = 8,
    parameter int NOISE_W = 16
);
    logic                       start;
    logic                       abort;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*DATA_W-1:0]    PeriodData;
    logic [LANES*NOISE_W-1:0]   BgNoise;
    logic                       noise_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output start, abort, in_valid, PeriodData,
        input  in_ready, BgNoise, noise_valid, busy, done
    );

    modport slave (
        input  start, abort, in_valid, PeriodData,
        output in_ready, BgNoise, noise_valid, busy, done
    );
endinterface

// File: rtl/bg_noise_estimator.sv
// Background-noise estimator: averages 2^LOG2_AVG noise-only period vectors
// per lane and publishes a held per-lane noise vector for the subtractor.

// One lane: sign-extending accumulator plus the published noise word.
module bg_noise_lane #(
    parameter int DATA_W   = 8,
    parameter int NOISE_W  = 16,
    parameter int LOG2_AVG = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       acc_en,
    input  logic                       fin,
    input  logic signed [DATA_W-1:0]   sample,
    output logic signed [NOISE_W-1:0]  noise
);
    localparam int ACC_W = DATA_W + LOG2_AVG;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] avg;

    // Floor division by N; the result always fits in DATA_W bits.
    assign avg = acc >>> LOG2_AVG;

    // Lane sum: cleared on start, grows by one sign-extended sample per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + ACC_W'(sample);
    end

    // Published word only moves on the FINAL edge, so it stays stable while recalibrating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            noise <= '0;
        else if (fin)
            noise <= NOISE_W'(avg);
    end
endmodule

module bg_noise_estimator #(
    parameter int LANES    = 16,
    parameter int DATA_W   = 8,
    parameter int NOISE_W  = 16,
    parameter int LOG2_AVG = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    bg_noise_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

    state_t                           state, state_nxt;
    logic [LOG2_AVG-1:0]              cnt;
    logic                             clr, acc_en, fin;
    logic                             in_ready, busy;
    logic                             done_q, noise_valid_q;
    logic [LANES-1:0][DATA_W-1:0]     samples;
    logic [LANES-1:0][NOISE_W-1:0]    noise;

    assign samples         = bus.PeriodData;
    assign bus.BgNoise     = noise;
    assign bus.in_ready    = in_ready;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.noise_valid = noise_valid_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and control decode; abort wins over a simultaneous valid vector.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        clr       = 1'b0;
        acc_en    = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clr       = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.in_valid) begin
                    acc_en = 1'b1;
                    if (cnt == {LOG2_AVG{1'b1}})
                        state_nxt = FINAL;
                end
            end
            FINAL: begin
                busy      = 1'b1;
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept counter; wraps to 0 on the last accept of a calibration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (acc_en)
            cnt <= cnt + LOG2_AVG'(1);
    end

    // done pulses with the BgNoise update; noise_valid is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q        <= 1'b0;
            noise_valid_q <= 1'b0;
        end else begin
            done_q        <= fin;
            noise_valid_q <= noise_valid_q | fin;
        end
    end

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            bg_noise_lane #(
                .DATA_W   (DATA_W),
                .NOISE_W  (NOISE_W),
                .LOG2_AVG (LOG2_AVG)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .acc_en (acc_en),
                .fin    (fin),
                .sample (samples[i]),
                .noise  (noise[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_bg_noise_estimator.sv
// Scoreboard bench for bg_noise_estimator: expected vectors are queued when a
// calibration is driven and compared when done pulses.
module tb_bg_noise_estimator;
    localparam int LANES = 16, DATA_W = 8, NOISE_W = 16, LOG2_AVG = 4;
    localparam int NV = 1 << LOG2_AVG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [LANES*DATA_W-1:0]  vq [NV];
    logic [LANES*NOISE_W-1:0] sb [$];

    bg_noise_if #(.LANES(LANES), .DATA_W(DATA_W), .NOISE_W(NOISE_W)) bus ();

    bg_noise_estimator #(
        .LANES(LANES), .DATA_W(DATA_W), .NOISE_W(NOISE_W), .LOG2_AVG(LOG2_AVG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*DATA_W-1:0] splat8(input logic [7:0] b);
        logic [LANES*DATA_W-1:0] v;
        for (int l = 0; l < LANES; l++) v[DATA_W*l +: DATA_W] = b;
        return v;
    endfunction

    function automatic logic [LANES*NOISE_W-1:0] splat16(input logic [15:0] w);
        logic [LANES*NOISE_W-1:0] v;
        for (int l = 0; l < LANES; l++) v[NOISE_W*l +: NOISE_W] = w;
        return v;
    endfunction

    // Reference: integer sum then floor division toward minus infinity.
    function automatic logic [LANES*NOISE_W-1:0] model();
        logic [LANES*NOISE_W-1:0] r;
        logic signed [7:0] b;
        int sum, q;
        for (int l = 0; l < LANES; l++) begin
            sum = 0;
            for (int v = 0; v < NV; v++) begin
                b = vq[v][DATA_W*l +: DATA_W];
                sum += int'(b);
            end
            q = sum / NV;
            if ((sum % NV) != 0 && sum < 0) q = q - 1;
            r[NOISE_W*l +: NOISE_W] = 16'(q);
        end
        return r;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [LANES*DATA_W-1:0] v, input bit gaps, input bit with_start);
        int g = 0;
        if (gaps) begin
            while ($urandom_range(1) == 1 && g < 6) begin
                bus.PeriodData = splat8(8'h40);
                bus.in_valid   = 1'b0;
                @(posedge clk); #1;
                g++;
            end
        end
        bus.PeriodData = v;
        bus.in_valid   = 1'b1;
        bus.start      = with_start;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.start      = 1'b0;
    endtask

    // Full calibration over vq[]; checks the FINAL cycle and done latency.
    task automatic run_cal(input bit gaps, input bit junk_at_start, input bit start_mid);
        sb.push_back(model());
        bus.start = 1'b1;
        if (junk_at_start) begin
            bus.in_valid   = 1'b1;
            bus.PeriodData = splat8(8'h7F);
        end
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        for (int v = 0; v < NV; v++) send(vq[v], gaps, start_mid && v == 5);
        @(negedge clk);
        chk("final_busy", {255'd0, bus.busy}, 256'd1);
        chk("final_no_done", {255'd0, bus.done}, 256'd0);
        @(negedge clk);
        chk("done_latency", {255'd0, bus.done}, 256'd1);
        chk("idle_busy", {255'd0, bus.busy}, 256'd0);
        @(negedge clk);
        chk("done_one_cycle", {255'd0, bus.done}, 256'd0);
    endtask

    // Scoreboard monitor: every done must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {255'd0, bus.done}, 256'd0);
                end else begin
                    chk("bgnoise", bus.BgNoise, sb.pop_front());
                    chk("noise_valid", {255'd0, bus.noise_valid}, 256'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.PeriodData = '0;
        #12;
        chk("rst_bgnoise", bus.BgNoise, 256'd0);
        chk("rst_status", {251'd0, bus.noise_valid, bus.busy, bus.done, bus.in_ready},
            256'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // all lanes 5, with a vector presented alongside start that must be ignored
        for (int v = 0; v < NV; v++) vq[v] = splat8(8'd5);
        run_cal(1'b0, 1'b1, 1'b0);
        chk("all5_const", bus.BgNoise, splat16(16'h0005));

        // extremes on lanes 0..2
        for (int v = 0; v < NV; v++) begin
            vq[v] = '0;
            vq[v][7:0] = 8'h80; vq[v][15:8] = 8'h7F; vq[v][23:16] = 8'hFD;
        end
        run_cal(1'b0, 1'b0, 1'b0);
        chk("lane0_min", {240'd0, bus.BgNoise[15:0]}, 256'h0000FF80);
        chk("lane2_neg", {240'd0, bus.BgNoise[47:32]}, 256'h0000FFFD);

        // floor behaviour for small positive and negative sums
        for (int v = 0; v < NV; v++) begin
            vq[v] = '0;
            vq[v][7:0]  = (v % 2) ? 8'h01 : 8'h00;
            vq[v][15:8] = (v % 2) ? 8'h00 : 8'hFF;
        end
        run_cal(1'b0, 1'b0, 1'b0);
        chk("floor_neg", {240'd0, bus.BgNoise[31:16]}, 256'h0000FFFF);

        // random valid gaps, values 1..16, start during ACCUM ignored
        for (int v = 0; v < NV; v++) vq[v] = splat8(8'(v + 1));
        run_cal(1'b1, 1'b0, 1'b1);
        chk("gaps_const", bus.BgNoise, splat16(16'h0008));

        // abort after 7 accepts keeps the previous estimate
        for (int v = 0; v < NV; v++) vq[v] = splat8(8'd5);
        run_cal(1'b0, 1'b0, 1'b0);
        pulse_start();
        for (int v = 0; v < 7; v++) send(splat8(8'd9), 1'b0, 1'b0);
        bus.PeriodData = splat8(8'd9); bus.in_valid = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.abort = 1'b0;
        chk("abort_idle", {254'd0, bus.busy, bus.in_ready}, 256'd0);
        chk("abort_hold", bus.BgNoise, splat16(16'h0005));
        chk("abort_valid", {255'd0, bus.noise_valid}, 256'd1);
        repeat (3) @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++) vq[v] = splat8(8'hFE);
        run_cal(1'b0, 1'b0, 1'b0);
        chk("after_abort", bus.BgNoise, splat16(16'hFFFE));

        // asynchronous reset mid-ACCUM
        pulse_start();
        for (int v = 0; v < 3; v++) send(splat8(8'd3), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bgnoise", bus.BgNoise, 256'd0);
        chk("arst_status", {253'd0, bus.noise_valid, bus.busy, bus.in_ready}, 256'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int v = 0; v < NV; v++) vq[v] = splat8(8'd7);
        run_cal(1'b0, 1'b0, 1'b0);
        chk("post_rst", bus.BgNoise, splat16(16'h0007));

        chk("sb_drained", 256'(sb.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bg_noise_estimator.md
Name: bg_noise_estimator

Overview:
- Produces the per-lane background-noise vector consumed by the detection-path noise subtractor.
- On a start request, accumulates a power-of-two number of noise-only period vectors (16 lanes of signed 8-bit samples) and divides each lane sum by the sample count.
- Publishes the result as a 16-lane signed 16-bit vector.
- The vector is held stable until the next successful calibration completes.

Parameters:
- LANES, 16, number of sample lanes per period vector.
- DATA_W, 8, signed input sample width per lane.
- NOISE_W, 16, signed output noise width per lane.
- LOG2_AVG, 4, log2 of the number of period vectors averaged (N = 2^LOG2_AVG).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a calibration (honoured in IDLE only).
- abort  in  1  pulse: discard the calibration in progress.
- in_valid  in  1  PeriodData holds a valid noise-only vector.
- in_ready  out  1  estimator accepts a vector this cycle.
- PeriodData  in  LANES*DATA_W  lane i at bits [DATA_W*i +: DATA_W], two's complement.
- BgNoise  out  LANES*NOISE_W  lane i at bits [NOISE_W*i +: NOISE_W], two's complement.
- noise_valid  out  1  BgNoise holds at least one completed estimate.
- busy  out  1  calibration in progress (ACCUM or FINAL).
- done  out  1  one-cycle pulse when BgNoise is updated.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - Counter, accumulators and BgNoise are 0.
  - noise_valid, busy, done and in_ready are 0.
- States: IDLE, ACCUM, FINAL.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 clears all accumulators and the counter, then goes to ACCUM.
  - abort in IDLE is ignored.
- ACCUM:
  - in_ready=1, busy=1.
  - An accept is in_valid & in_ready at a rising edge. On each accept, every lane accumulator adds its sign-extended sample.
  - The counter increments on each accept.
  - The accept with counter == N-1 moves the state to FINAL.
  - in_valid gaps of any length are allowed; nothing changes without an accept.
  - start is ignored in ACCUM.
  - abort=1 goes to IDLE with no accumulation that edge, even if in_valid=1. BgNoise and noise_valid are unchanged and no done pulse is issued.
- FINAL (exactly one cycle):
  - in_ready=0, busy=1, abort ignored.
  - At the next edge: BgNoise lane i <= sign-extend(acc_i >>> LOG2_AVG), noise_valid <= 1, done <= 1 for one cycle, state -> IDLE.
- Arithmetic:
  - Accumulators are signed DATA_W+LOG2_AVG bits (12 by default); range -2048..2032 cannot overflow.
  - Division is an arithmetic right shift, i.e. floor toward minus infinity, with no rounding.
  - Result range is -128..127, sign-extended to NOISE_W.
- Latency: the final accept at edge k gives FINAL after edge k, then BgNoise, noise_valid and done update at edge k+1. Minimum calibration is N+1 edges after start is sampled.
- Output stability:
  - BgNoise changes only at the FINAL edge.
  - During recalibration, the previous estimate and noise_valid=1 remain visible.
- Simultaneous start and in_valid in IDLE: the vector is not accepted (in_ready=0 in IDLE); accumulation begins next cycle.
- Reset mid-calibration returns to the reset values; the previous BgNoise is lost and reads 0.
- done and start may coincide only across cycles. A start in the cycle done is high (state IDLE) is honoured.

Test Plan:
- Reset, start, then 16 back-to-back vectors with all lanes = 5 -> done once 2 edges after the last accept; every BgNoise lane 0x0005; noise_valid=1; busy=0 afterwards.
- Lane 0 constant -128, lane 1 constant 127, lane 2 constant -3, 16 vectors -> lanes 0xFF80, 0x007F, 0xFFFD.
- Floor check: lane 0 alternates 0/1 (sum 8), lane 1 alternates -1/0 (sum -8) -> lane 0 = 0x0000, lane 1 = 0xFFFF.
- Randomised in_valid gaps (~50%) with values 1..16 per vector (sum 136) -> all lanes 0x0008; no accept while in_valid=0; start during ACCUM is ignored.
- Complete a calibration to value 5, start a new one, abort after 7 accepts while in_valid=1 -> state IDLE, BgNoise still 0x0005, no done pulse; a fresh calibration with all lanes -2 yields 0xFFFE.
- Assert rst_n=0 mid-ACCUM after a completed estimate -> BgNoise=0 and noise_valid, busy, in_ready all 0 asynchronously; after release, start works normally.
